// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pipe_pkg
//  Purpose  : Shared widths, NOP encoding and the IF/ID entry type for the
//             MIPS pipeline registers (IF/ID and its IDEX/EXMEM successors).
//  Contents : MIPS_ADDR_W     default width of the PC+4 path
//             MIPS_INSTR_W    default width of the instruction word
//             MIPS_NOP_INSTR  sll $0,$0,0 encoding (all zeros)
//             ifid_entry_t    {pc, instr, hit} payload of one IF/ID entry
//             ifid_pack       helper that packs the three fields
//  Revision : 1.0  initial release
// ============================================================================
package mips_pipe_pkg;

    localparam int MIPS_ADDR_W  = 32;
    localparam int MIPS_INSTR_W = 32;
    localparam logic [MIPS_INSTR_W-1:0] MIPS_NOP_INSTR = '0;

    typedef struct packed {
        logic [MIPS_ADDR_W-1:0]  pc;
        logic [MIPS_INSTR_W-1:0] instr;
        logic                    hit;
    } ifid_entry_t;

    function automatic ifid_entry_t ifid_pack(
        input logic [MIPS_ADDR_W-1:0]  pc,
        input logic [MIPS_INSTR_W-1:0] instr,
        input logic                    hit
    );
        ifid_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        e.hit   = hit;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifid_skid_slot.sv
`default_nettype none
// ============================================================================
//  Module   : ifid_skid_slot
//  Purpose  : Single-entry holding register with a valid flag. Used twice in
//             the IF/ID stage: once as the main (ID-facing) register and once
//             as the skid entry that absorbs one beat of back-pressure.
//  Ports    : clk    in   rising-edge clock
//             rst    in   asynchronous active-high reset
//             load   in   capture d and mark valid
//             clear  in   mark empty (wins over load; data is left untouched)
//             d      in   W-bit payload
//             valid  out  slot holds an entry
//             q      out  held payload (unchanged while not loading)
//  Revision : 1.0  initial release
// ============================================================================
module ifid_skid_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule
`default_nettype wire

// File: rtl/ifid_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : ifid_pipe_reg
//  Purpose  : IF/ID pipeline register with valid/ready handshake, a 2-entry
//             skid buffer (main + skid slot) and flush. Carries PC+4, the
//             instruction word and the branch-predictor hit bit to decode.
//  Options  : IFID_PERF_CNT_EN  adds CNT_W parameter, stall_cnt/flush_cnt
//                               ports and saturating performance counters.
//  Ports    : clk, rst (async active-high), flush
//             in_valid/in_ready, nextPC, Instruction, hit       (IF side)
//             out_valid/out_ready, nextPC_out, instruction_out,
//             hit_out                                           (ID side)
//             stall_cnt, flush_cnt                (IFID_PERF_CNT_EN only)
//  Revision : 1.0  initial release
// ============================================================================
module ifid_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int                 ADDR_W    = MIPS_ADDR_W,
    parameter int                 INSTR_W   = MIPS_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
`ifdef IFID_PERF_CNT_EN
    ,
    parameter int                 CNT_W     = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  nextPC,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               hit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  nextPC_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               hit_out
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    // Entry layout: {pc, instr, hit}, same field order as ifid_entry_t.
    localparam int ENTRY_W = ADDR_W + INSTR_W + 1;

    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_main_d;
    logic [ENTRY_W-1:0] w_main_q;
    logic [ENTRY_W-1:0] w_skid_q;
    logic               w_main_valid;
    logic               w_skid_valid;
    logic               w_main_load;
    logic               w_main_clear;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic               w_in_fire;
    logic               w_main_open;

    assign w_in_entry = {nextPC, Instruction, hit};

    // in_ready comes straight from the skid flop, so there is no
    // combinational path from out_ready back to the fetch stage.
    assign in_ready    = !w_skid_valid;
    assign w_in_fire   = in_valid & in_ready;
    assign w_main_open = !w_main_valid | out_ready;

    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_main_d     = w_in_entry;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (flush) begin
            // Drops held entries and whatever IF offers this cycle. If ID
            // also takes the current entry, that consumption still stands.
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_main_open) begin
            if (w_skid_valid) begin
                // Older skid entry drains first; in_ready is low so no new
                // input can be accepted this cycle.
                w_main_load  = 1'b1;
                w_main_d     = w_skid_q;
                w_skid_clear = 1'b1;
            end else if (w_in_fire) begin
                w_main_load  = 1'b1;
            end else begin
                // Main was empty or just consumed, and nothing replaces it.
                w_main_clear = 1'b1;
            end
        end else if (w_in_fire) begin
            // Main is stalled: park the accepted entry in the skid slot.
            w_skid_load = 1'b1;
        end
    end

    ifid_skid_slot #(
        .W (ENTRY_W)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (w_main_load),
        .clear (w_main_clear),
        .d     (w_main_d),
        .valid (w_main_valid),
        .q     (w_main_q)
    );

    ifid_skid_slot #(
        .W (ENTRY_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (w_skid_load),
        .clear (w_skid_clear),
        .d     (w_in_entry),
        .valid (w_skid_valid),
        .q     (w_skid_q)
    );

    assign out_valid       = w_main_valid;
    assign nextPC_out      = w_main_q[ENTRY_W-1 -: ADDR_W];
    assign instruction_out = w_main_valid ? w_main_q[INSTR_W:1] : NOP_INSTR;
    assign hit_out         = w_main_valid & w_main_q[0];

`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    logic             w_stall;
    logic             w_discard;

    assign w_stall   = w_main_valid & !out_ready;
    // A flush discards something if the main entry is not being consumed,
    // the skid holds an entry, or IF is offering an acceptable entry.
    assign w_discard = flush & ((w_main_valid & !out_ready) | w_skid_valid | w_in_fire);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (w_discard && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire
